branch_fetch_unit: RTL and testbench

BRANCH_FETCH_UNIT -- requirements
Module: branch_fetch_unit

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/branch_fetch_unit_if.sv | 39 +++
 rtl/sat_counter16.sv | 28 ++
 rtl/branch_fetch_unit.sv | 130 +++++++++++++
 tb/tb_branch_fetch_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared constants and types for the branch fetch unit.
//   RESET_PC  : fetch address after reset
//   PC_STEP   : sequential fetch increment
//   NOP_INSTR : instruction word used for a squashed IF/ID slot
//   fetch_state_t : fetch FSM encoding (RUN=0, PENDING=1)
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic {
    RUN     = 1'b0,
    PENDING = 1'b1
  } fetch_state_t;

  // Fetch addresses are word aligned; the low two bits of a target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/branch_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// branch_fetch_unit_if
// Signal bundle between the pipeline (master) and the fetch unit (slave).
//   master -> slave : control_hazard, branch_target, load_enable, imem_instr
//   slave -> master : pc, npc, ifid_instr, ifid_pc, ifid_valid,
//                     redirect_pending, redirect_count
// Handshake: there is no valid/ready pair. load_enable acts as the single
// "advance" qualifier: when 1 the fetch unit consumes imem_instr and the
// redirect request (if any) on that rising edge; when 0 it holds its state,
// except that a taken branch seen in RUN is captured for later.
// ---------------------------------------------------------------------------
interface branch_fetch_unit_if;

  logic        control_hazard;
  logic [31:0] branch_target;
  logic        load_enable;
  logic [31:0] imem_instr;

  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic        redirect_pending;
  logic [15:0] redirect_count;

  modport master (
    output control_hazard, branch_target, load_enable, imem_instr,
    input  pc, npc, ifid_instr, ifid_pc, ifid_valid,
           redirect_pending, redirect_count
  );

  modport slave (
    input  control_hazard, branch_target, load_enable, imem_instr,
    output pc, npc, ifid_instr, ifid_pc, ifid_valid,
           redirect_pending, redirect_count
  );

endinterface

// File: rtl/sat_counter16.sv
// ---------------------------------------------------------------------------
// sat_counter16
// 16-bit up counter that sticks at 16'hFFFF instead of wrapping.
//   clk     : rising-edge clock
//   i_rst   : synchronous active-high reset (clears to 0)
//   i_en    : count enable
//   o_count : current count
// ---------------------------------------------------------------------------
module sat_counter16 (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic [15:0] o_count
);

  logic [15:0] r_count;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_count <= 16'h0;
    end else if (i_en && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/branch_fetch_unit.sv
// ---------------------------------------------------------------------------
// branch_fetch_unit
// Instruction fetch stage with branch redirect and IF/ID register.
//   clk         : rising-edge clock
//   reset       : synchronous active-high reset
//   bus         : branch_fetch_unit_if.slave (hazard/stall/imem in,
//                 pc/npc/IF-ID/redirect status out)
//   o_dbg_state : current FSM state (RUN/PENDING)
// A taken branch arriving during a stall is parked in pending_target and
// applied on the next cycle with load_enable=1; later branches seen while
// parked are dropped (the first captured target wins).
// Build option: define BRANCH_DELAY_SLOT_EN to keep the instruction fetched
// alongside a redirect as a valid delay slot; otherwise that slot is squashed.
// ---------------------------------------------------------------------------
module branch_fetch_unit
  import fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  branch_fetch_unit_if.slave   bus,
  output fetch_state_t         o_dbg_state
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;

  logic [31:0] r_pc;
  logic [31:0] r_npc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc;
  logic        r_ifid_valid;
  logic [31:0] r_pending_target;
  logic        r_redirect_pending;

  logic        w_advance;     // plain sequential step
  logic        w_apply;       // redirect applied this edge
  logic        w_capture;     // park branch_target in pending_target
  logic [31:0] w_target;
  logic [31:0] w_redirect_pc;
  logic [15:0] w_count;

  // Next-state and step decode.
  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    w_apply      = 1'b0;
    w_capture    = 1'b0;
    w_target     = r_pending_target;
    case (r_state)
      RUN: begin
        if (bus.load_enable) begin
          if (bus.control_hazard) begin
            w_apply  = 1'b1;
            w_target = bus.branch_target;
          end else begin
            w_advance = 1'b1;
          end
        end else if (bus.control_hazard) begin
          w_capture    = 1'b1;
          w_state_next = PENDING;
        end
      end
      PENDING: begin
        // control_hazard is deliberately not looked at here.
        if (bus.load_enable) begin
          w_apply      = 1'b1;
          w_target     = r_pending_target;
          w_state_next = RUN;
        end
      end
      default: w_state_next = RUN;
    endcase
    w_redirect_pc = align_pc(w_target);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= RUN;
      r_pc               <= RESET_PC;
      r_npc              <= RESET_PC + PC_STEP;
      r_ifid_instr       <= NOP_INSTR;
      r_ifid_pc          <= 32'h0;
      r_ifid_valid       <= 1'b0;
      r_pending_target   <= 32'h0;
      r_redirect_pending <= 1'b0;
    end else begin
      r_state            <= w_state_next;
      r_redirect_pending <= (w_state_next == PENDING);
      if (w_capture) begin
        r_pending_target <= bus.branch_target;
      end
      if (w_advance) begin
        r_ifid_instr <= bus.imem_instr;
        r_ifid_pc    <= r_pc;
        r_ifid_valid <= 1'b1;
        r_pc         <= r_npc;
        r_npc        <= r_npc + PC_STEP;
      end else if (w_apply) begin
        r_pc  <= w_redirect_pc;
        r_npc <= w_redirect_pc + PC_STEP;
`ifdef BRANCH_DELAY_SLOT_EN
        r_ifid_instr <= bus.imem_instr;
        r_ifid_pc    <= r_pc;
        r_ifid_valid <= 1'b1;
`else
        // Squash the wrong-path fetch; ifid_pc keeps its last value.
        r_ifid_instr <= NOP_INSTR;
        r_ifid_valid <= 1'b0;
`endif
      end
    end
  end

  sat_counter16 u_redirect_cnt (
    .clk     (clk),
    .i_rst   (reset),
    .i_en    (w_apply),
    .o_count (w_count)
  );

  assign bus.pc               = r_pc;
  assign bus.npc              = r_npc;
  assign bus.ifid_instr       = r_ifid_instr;
  assign bus.ifid_pc          = r_ifid_pc;
  assign bus.ifid_valid       = r_ifid_valid;
  assign bus.redirect_pending = r_redirect_pending;
  assign bus.redirect_count   = w_count;
  assign o_dbg_state          = r_state;

endmodule

// File: tb/tb_branch_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_fetch_unit
// Bench for branch_fetch_unit: a behavioural reference model predicts every
// output after each driven cycle; the prediction is queued and compared once
// the DUT has clocked. Directed checks cover the documented scenarios.
// ---------------------------------------------------------------------------
module tb_branch_fetch_unit;
  import fetch_pkg::*;

  localparam int EW = 147;

  logic clk;
  logic reset;
  fetch_state_t dbg_state;

  branch_fetch_unit_if bus_if ();

  branch_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_state;
  logic [31:0] m_pc, m_npc, m_ifid_instr, m_ifid_pc, m_pend;
  logic        m_ifid_valid;
  logic [15:0] m_count;

  task automatic model_apply(input logic [31:0] t, input logic [31:0] instr);
`ifdef BRANCH_DELAY_SLOT_EN
    m_ifid_instr = instr;
    m_ifid_pc    = m_pc;
    m_ifid_valid = 1'b1;
`else
    m_ifid_instr = 32'h0;
    m_ifid_valid = 1'b0;
    if (instr == 32'h0) m_ifid_valid = 1'b0;
`endif
    m_pc  = {t[31:2], 2'b00};
    m_npc = m_pc + 32'd4;
    if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
  endtask

  task automatic model_step(input logic rst, input logic ch, input logic [31:0] bt,
                            input logic le, input logic [31:0] instr);
    if (rst) begin
      m_state = 1'b0; m_pc = 32'h0; m_npc = 32'd4;
      m_ifid_instr = 32'h0; m_ifid_pc = 32'h0; m_ifid_valid = 1'b0;
      m_pend = 32'h0; m_count = 16'h0;
    end else if (m_state == 1'b0) begin
      if (le && ch) begin
        model_apply(bt, instr);
      end else if (le) begin
        m_ifid_instr = instr; m_ifid_pc = m_pc; m_ifid_valid = 1'b1;
        m_pc = m_npc; m_npc = m_npc + 32'd4;
      end else if (ch) begin
        m_pend = bt; m_state = 1'b1;
      end
    end else if (le) begin
      model_apply(m_pend, instr);
      m_state = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic rst, input logic ch, input logic [31:0] bt,
                             input logic le, input logic [31:0] instr, input bit chk);
    logic [EW-1:0] e;
    @(negedge clk);
    reset                 = rst;
    bus_if.control_hazard = ch;
    bus_if.branch_target  = bt;
    bus_if.load_enable    = le;
    bus_if.imem_instr     = instr;
    model_step(rst, ch, bt, le, instr);
    if (chk) exp_q.push_back({m_state, m_state, m_count, m_ifid_valid, m_ifid_pc,
                              m_ifid_instr, m_npc, m_pc});
    @(posedge clk);
    #1;
    if (chk) begin
      e = exp_q.pop_front();
      check_eq("pc",         bus_if.pc,                   e[31:0]);
      check_eq("npc",        bus_if.npc,                  e[63:32]);
      check_eq("ifid_instr", bus_if.ifid_instr,           e[95:64]);
      check_eq("ifid_pc",    bus_if.ifid_pc,              e[127:96]);
      check_eq("ifid_valid", {31'b0, bus_if.ifid_valid},  {31'b0, e[128]});
      check_eq("count",      {16'b0, bus_if.redirect_count}, {16'b0, e[144:129]});
      check_eq("pending",    {31'b0, bus_if.redirect_pending}, {31'b0, e[145]});
      check_eq("state",      {31'b0, dbg_state},          {31'b0, e[146]});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    bus_if.control_hazard = 1'b0;
    bus_if.branch_target  = 32'h0;
    bus_if.load_enable    = 1'b0;
    bus_if.imem_instr     = 32'h0;

    // Reset, with busy inputs to show they are ignored.
    drive_cycle(1'b1, 1'b1, 32'h44, 1'b1, 32'hDEAD0000, 1'b1);
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_eq("rst_pc",  bus_if.pc,  32'h0);
    check_eq("rst_npc", bus_if.npc, 32'h4);

    // Three sequential fetches A, B, C.
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hAAAA0001, 1'b1);
    check_eq("first_ifid_pc", bus_if.ifid_pc, 32'h0);
    check_eq("first_valid", {31'b0, bus_if.ifid_valid}, 32'h1);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hBBBB0002, 1'b1);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hCCCC0003, 1'b1);
    check_eq("seq_pc",    bus_if.pc,         32'd12);
    check_eq("seq_npc",   bus_if.npc,        32'd16);
    check_eq("seq_instr", bus_if.ifid_instr, 32'hCCCC0003);
    check_eq("seq_ifpc",  bus_if.ifid_pc,    32'd8);

    // Plain stall holds everything.
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h12345678, 1'b1);
    check_eq("stall_pc", bus_if.pc, 32'd12);

    // Redirect to an unaligned target while advancing.
    drive_cycle(1'b0, 1'b1, 32'h103, 1'b1, 32'hDDDD0004, 1'b1);
    check_eq("redir_pc",  bus_if.pc,  32'h100);
    check_eq("redir_npc", bus_if.npc, 32'h104);
    check_eq("redir_cnt", {16'b0, bus_if.redirect_count}, 32'h1);
`ifdef BRANCH_DELAY_SLOT_EN
    check_eq("ds_ifpc",  bus_if.ifid_pc, 32'd12);
    check_eq("ds_valid", {31'b0, bus_if.ifid_valid}, 32'h1);
`else
    check_eq("sq_instr", bus_if.ifid_instr, 32'h0);
    check_eq("sq_valid", {31'b0, bus_if.ifid_valid}, 32'h0);
`endif

    // Branch during stall: first target wins, later hazards ignored.
    drive_cycle(1'b0, 1'b1, 32'h200, 1'b0, 32'h1, 1'b1);
    check_eq("pend_1", {31'b0, bus_if.redirect_pending}, 32'h1);
    drive_cycle(1'b0, 1'b1, 32'h300, 1'b0, 32'h2, 1'b1);
    drive_cycle(1'b0, 1'b1, 32'h300, 1'b0, 32'h3, 1'b1);
    check_eq("pend_3", {31'b0, bus_if.redirect_pending}, 32'h1);
    check_eq("pend_hold_pc", bus_if.pc, 32'h100);
    drive_cycle(1'b0, 1'b1, 32'h400, 1'b1, 32'h4, 1'b1);
    check_eq("pend_pc",  bus_if.pc, 32'h200);
    check_eq("pend_cnt", {16'b0, bus_if.redirect_count}, 32'h2);
    check_eq("pend_off", {31'b0, bus_if.redirect_pending}, 32'h0);

    // Reset while PENDING discards the captured target.
    drive_cycle(1'b0, 1'b1, 32'h500, 1'b0, 32'h5, 1'b1);
    drive_cycle(1'b1, 1'b1, 32'h600, 1'b1, 32'h6, 1'b1);
    check_eq("rstp_pc",  bus_if.pc, 32'h0);
    check_eq("rstp_pnd", {31'b0, bus_if.redirect_pending}, 32'h0);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h7, 1'b1);
    check_eq("rstp_adv", bus_if.pc, 32'h4);
    check_eq("rstp_cnt", {16'b0, bus_if.redirect_count}, 32'h0);

    // Address wrap at the top of the space.
    drive_cycle(1'b0, 1'b1, 32'hFFFFFFF8, 1'b1, 32'h8, 1'b1);
    check_eq("wrap_npc0", bus_if.npc, 32'hFFFFFFFC);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h9, 1'b1);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hA, 1'b1);
    check_eq("wrap_pc",  bus_if.pc,  32'h0);
    check_eq("wrap_npc", bus_if.npc, 32'h4);

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      drive_cycle($urandom_range(0, 31) == 0, $urandom_range(0, 2) == 0,
                  $urandom, $urandom_range(0, 3) != 0, $urandom, 1'b1);
    end

    // Saturation: clear, run the counter to 16'hFFFE, then 3 more redirects.
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 65534; i++) begin
      drive_cycle(1'b0, 1'b1, $urandom, 1'b1, $urandom, 1'b0);
    end
    check_eq("sat_pre", {16'b0, bus_if.redirect_count}, 32'h0000FFFE);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, $urandom, 1'b1, $urandom, 1'b1);
    end
    check_eq("sat_cnt", {16'b0, bus_if.redirect_count}, 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
